// File: rtl/alu_secuencial_if.sv
// Handshake and data bundle between the datapath controller and alu_secuencial.
// The controller drives the request side; the ALU drives status, result and flags.
interface alu_secuencial_if #(
    parameter int BITS_DATA   = 32,
    parameter int BITS_OPCODE = 5
);
    logic                   start;
    logic [BITS_OPCODE-1:0] opcode;
    logic [BITS_DATA-1:0]   operando_a;
    logic [BITS_DATA-1:0]   operando_b;
    logic                   busy;
    logic                   done;
    logic [BITS_DATA-1:0]   resultado;
    logic                   C;
    logic                   S;
    logic                   O;
    logic                   Z;
    logic                   err;

    modport master (
        output start, opcode, operando_a, operando_b,
        input  busy, done, resultado, C, S, O, Z, err
    );

    modport slave (
        input  start, opcode, operando_a, operando_b,
        output busy, done, resultado, C, S, O, Z, err
    );
endinterface

// File: rtl/alu_secuencial.sv
// Registered multi-cycle ALU: single-cycle logic/arith ops, shift-add multiply and
// restoring unsigned divide, with start/busy/done handshake and registered flags.
module alu_secuencial #(
    parameter int BITS_DATA   = 32,
    parameter int BITS_OPCODE = 5
) (
    input  logic              clk,
    input  logic              reset,
    alu_secuencial_if.slave   bus
);
    localparam int BITS_CNT = $clog2(BITS_DATA) + 1;

    // Encodings mirror the shared opcode header.
    localparam logic [BITS_OPCODE-1:0] OP_NOP = BITS_OPCODE'(5'd0);
    localparam logic [BITS_OPCODE-1:0] OP_ADD = BITS_OPCODE'(5'd1);
    localparam logic [BITS_OPCODE-1:0] OP_SUB = BITS_OPCODE'(5'd2);
    localparam logic [BITS_OPCODE-1:0] OP_AND = BITS_OPCODE'(5'd3);
    localparam logic [BITS_OPCODE-1:0] OP_OR  = BITS_OPCODE'(5'd4);
    localparam logic [BITS_OPCODE-1:0] OP_XOR = BITS_OPCODE'(5'd5);
    localparam logic [BITS_OPCODE-1:0] OP_NOT = BITS_OPCODE'(5'd6);
    localparam logic [BITS_OPCODE-1:0] OP_NEG = BITS_OPCODE'(5'd7);
    localparam logic [BITS_OPCODE-1:0] OP_MUL = BITS_OPCODE'(5'd8);
    localparam logic [BITS_OPCODE-1:0] OP_DIV = BITS_OPCODE'(5'd9);
    localparam logic [BITS_OPCODE-1:0] OP_MOD = BITS_OPCODE'(5'd10);
    localparam logic [BITS_OPCODE-1:0] OP_HLT = BITS_OPCODE'(5'd31);

    localparam logic [BITS_DATA-1:0] ZERO    = {BITS_DATA{1'b0}};
    localparam logic [BITS_DATA-1:0] ONES    = {BITS_DATA{1'b1}};
    localparam logic [BITS_DATA-1:0] MIN_NEG = {1'b1, {(BITS_DATA-1){1'b0}}};

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        ITER_MUL = 3'd2,
        ITER_DIV = 3'd3,
        FIN      = 3'd4
    } state_t;

    state_t                 state_r, next_s;
    logic [BITS_CNT-1:0]    cnt_r;
    logic [BITS_DATA-1:0]   a_r, b_r;
    logic [BITS_OPCODE-1:0] op_r;
    logic [BITS_DATA-1:0]   acc_hi_r, acc_lo_r;
    logic [BITS_DATA-1:0]   resultado_r;
    logic                   busy_r, done_r, c_r, s_r, o_r, z_r, err_r;

    logic [BITS_DATA:0]     mul_sum_s, div_shift_s, div_trial_s, add_s;
    logic                   div_ge_s;
    logic [BITS_DATA-1:0]   sub_s, res_s;
    logic                   c_s, o_s, err_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_r <= IDLE;
        else       state_r <= next_s;
    end

    // Next-state decode; zero divisors skip iteration and take the error path.
    always_comb begin
        next_s = state_r;
        case (state_r)
            IDLE: begin
                if (bus.start) begin
                    if (bus.opcode == OP_MUL)
                        next_s = ITER_MUL;
                    else if ((bus.opcode == OP_DIV || bus.opcode == OP_MOD) && bus.operando_b != ZERO)
                        next_s = ITER_DIV;
                    else
                        next_s = EXEC;
                end else begin
                    next_s = IDLE;
                end
            end
            EXEC:               next_s = FIN;
            ITER_MUL, ITER_DIV: next_s = (cnt_r == BITS_CNT'(1'b1)) ? EXEC : state_r;
            FIN:                next_s = IDLE;
            default:            next_s = IDLE;
        endcase
    end

    // One iteration step of shift-add multiply and restoring division.
    always_comb begin
        mul_sum_s   = {1'b0, acc_hi_r} + (acc_lo_r[0] ? {1'b0, b_r} : {(BITS_DATA+1){1'b0}});
        div_shift_s = {acc_hi_r, acc_lo_r[BITS_DATA-1]};
        div_trial_s = div_shift_s - {1'b0, b_r};
        div_ge_s    = ~div_trial_s[BITS_DATA];
    end

    // Result and carry/overflow/error for the value committed in EXEC.
    always_comb begin
        add_s = {1'b0, a_r} + {1'b0, b_r};
        sub_s = a_r - b_r;
        res_s = ZERO;
        c_s   = 1'b0;
        o_s   = 1'b0;
        err_s = 1'b0;
        case (op_r)
            OP_NOT: res_s = ~a_r;
            OP_AND: res_s = a_r & b_r;
            OP_OR:  res_s = a_r | b_r;
            OP_XOR: res_s = a_r ^ b_r;
            OP_NEG: begin
                res_s = ZERO - a_r;
                c_s   = (a_r != ZERO);
                o_s   = (a_r == MIN_NEG);
            end
            OP_ADD: begin
                res_s = add_s[BITS_DATA-1:0];
                c_s   = add_s[BITS_DATA];
                o_s   = (a_r[BITS_DATA-1] == b_r[BITS_DATA-1]) && (add_s[BITS_DATA-1] != a_r[BITS_DATA-1]);
            end
            OP_SUB: begin
                res_s = sub_s;
                c_s   = (a_r < b_r);
                o_s   = (a_r[BITS_DATA-1] != b_r[BITS_DATA-1]) && (sub_s[BITS_DATA-1] != a_r[BITS_DATA-1]);
            end
            OP_MUL: begin
                res_s = acc_lo_r;
                c_s   = |acc_hi_r;
                o_s   = |acc_hi_r;
            end
            OP_DIV: begin
                if (b_r == ZERO) begin
                    res_s = ONES;
                    err_s = 1'b1;
                end else begin
                    res_s = acc_lo_r;
                end
            end
            OP_MOD: begin
                if (b_r == ZERO) begin
                    res_s = a_r;
                    err_s = 1'b1;
                end else begin
                    res_s = acc_hi_r;
                end
            end
            default: begin
                res_s = ZERO;
                err_s = 1'b1;
            end
        endcase
    end

    // Operand latch, iteration accumulators and committed result/flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r       <= {BITS_CNT{1'b0}};
            a_r         <= ZERO;
            b_r         <= ZERO;
            op_r        <= OP_NOP;
            acc_hi_r    <= ZERO;
            acc_lo_r    <= ZERO;
            resultado_r <= ZERO;
            c_r         <= 1'b0;
            s_r         <= 1'b0;
            o_r         <= 1'b0;
            z_r         <= 1'b1;
            err_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (bus.start) begin
                        a_r      <= bus.operando_a;
                        b_r      <= bus.operando_b;
                        op_r     <= bus.opcode;
                        acc_hi_r <= ZERO;
                        acc_lo_r <= bus.operando_a;
                        cnt_r    <= BITS_CNT'(BITS_DATA);
                    end
                end
                ITER_MUL: begin
                    acc_hi_r <= mul_sum_s[BITS_DATA:1];
                    acc_lo_r <= {mul_sum_s[0], acc_lo_r[BITS_DATA-1:1]};
                    cnt_r    <= cnt_r - BITS_CNT'(1'b1);
                end
                ITER_DIV: begin
                    acc_hi_r <= div_ge_s ? div_trial_s[BITS_DATA-1:0] : div_shift_s[BITS_DATA-1:0];
                    acc_lo_r <= {acc_lo_r[BITS_DATA-2:0], div_ge_s};
                    cnt_r    <= cnt_r - BITS_CNT'(1'b1);
                end
                EXEC: begin
                    resultado_r <= res_s;
                    c_r         <= c_s;
                    s_r         <= res_s[BITS_DATA-1];
                    o_r         <= o_s;
                    z_r         <= ~|res_s;
                    err_r       <= err_s;
                end
                default: ;
            endcase
        end
    end

    // Handshake outputs registered from the upcoming state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_s != IDLE);
            done_r <= (next_s == FIN);
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.resultado = resultado_r;
    assign bus.C         = c_r;
    assign bus.S         = s_r;
    assign bus.O         = o_r;
    assign bus.Z         = z_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_alu_secuencial.sv
// Directed self-checking bench for alu_secuencial (32-bit data, 5-bit opcode).
module tb_alu_secuencial;
    localparam logic [4:0] OP_ADD = 5'd1,  OP_SUB = 5'd2,  OP_AND = 5'd3, OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5,  OP_NOT = 5'd6,  OP_NEG = 5'd7, OP_MUL = 5'd8;
    localparam logic [4:0] OP_DIV = 5'd9,  OP_MOD = 5'd10, OP_HLT = 5'd31;

    logic clk = 1'b0;
    logic reset;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   lat;
    int   dones;
    int   first_done;

    alu_secuencial_if #(.BITS_DATA(32), .BITS_OPCODE(5)) bus ();

    alu_secuencial #(.BITS_DATA(32), .BITS_OPCODE(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {bus.C, bus.S, bus.O, bus.Z, bus.err};
    endfunction

    // Issue one request, scramble the pins while busy, stop at the negedge where done is seen.
    task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, output int l);
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = op; bus.operando_a = a; bus.operando_b = b;
        @(negedge clk);
        bus.start = 1'b0;
        bus.opcode = 5'($urandom); bus.operando_a = $urandom; bus.operando_b = $urandom;
        l = 1;
        while (bus.done !== 1'b1 && l < 100) begin
            @(negedge clk);
            l++;
        end
        chk("done_seen", 64'(bus.done), 64'(1'b1));
    endtask

    task automatic op_check(input string tag, input logic [4:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                            input logic [4:0] exp_flags);
        run_op(op, a, b, lat);
        chk({tag, "_lat"},   64'(lat),           64'(exp_lat));
        chk({tag, "_res"},   64'(bus.resultado), 64'(exp_res));
        chk({tag, "_flags"}, 64'(flags()),       64'(exp_flags));
    endtask

    // Flags are compared as {C,S,O,Z,err}.
    initial begin
        reset = 1'b1;
        bus.start = 1'b0; bus.opcode = 5'd0; bus.operando_a = 32'd0; bus.operando_b = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_res",   64'(bus.resultado), 64'h0);
        chk("rst_flags", 64'(flags()),       64'(5'b00010));
        chk("rst_busy",  64'(bus.busy),      64'h0);
        chk("rst_done",  64'(bus.done),      64'h0);
        reset = 1'b0;

        op_check("add_ovf",  OP_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 2,  32'h8000_0000, 5'b01100);
        op_check("sub_neg",  OP_SUB, 32'h0000_0003, 32'h0000_0005, 2,  32'hFFFF_FFFE, 5'b11000);
        op_check("sub_zero", OP_SUB, 32'h1234_5678, 32'h1234_5678, 2,  32'h0000_0000, 5'b00010);
        op_check("mul_hi",   OP_MUL, 32'h0001_0000, 32'h0001_0000, 34, 32'h0000_0000, 5'b10110);
        op_check("mul_7x6",  OP_MUL, 32'd7,         32'd6,         34, 32'd42,        5'b00000);
        op_check("div",      OP_DIV, 32'd100,       32'd7,         34, 32'd14,        5'b00000);
        op_check("mod",      OP_MOD, 32'd100,       32'd7,         34, 32'd2,         5'b00000);
        op_check("div_z",    OP_DIV, 32'd5,         32'd0,         2,  32'hFFFF_FFFF, 5'b01001);
        op_check("mod_z",    OP_MOD, 32'd5,         32'd0,         2,  32'd5,         5'b00001);
        op_check("neg_min",  OP_NEG, 32'h8000_0000, 32'd0,         2,  32'h8000_0000, 5'b11100);
        op_check("neg_one",  OP_NEG, 32'd1,         32'd0,         2,  32'hFFFF_FFFF, 5'b11000);
        op_check("not_zero", OP_NOT, 32'd0,         32'd0,         2,  32'hFFFF_FFFF, 5'b01000);
        op_check("and",      OP_AND, 32'hF0F0_F0F0, 32'hFFFF_0000, 2,  32'hF0F0_0000, 5'b01000);
        op_check("or",       OP_OR,  32'h0F00_0000, 32'h0000_0001, 2,  32'h0F00_0001, 5'b00000);
        op_check("add_cry",  OP_ADD, 32'hFFFF_FFFF, 32'h0000_0001, 2,  32'h0000_0000, 5'b10010);
        @(negedge clk);
        chk("done_pulse", 64'(bus.done), 64'h0);

        // MUL 3*5 with a second start pulsed at cycle 5 of the operation.
        @(negedge clk);
        bus.start = 1'b1; bus.opcode = OP_MUL; bus.operando_a = 32'd3; bus.operando_b = 32'd5;
        @(negedge clk);
        dones = 0; first_done = 0;
        for (int k = 1; k <= 45; k++) begin
            if (bus.done === 1'b1) begin
                dones++;
                if (first_done == 0) first_done = k;
            end
            if (k == 5) begin
                bus.start = 1'b1; bus.opcode = OP_ADD; bus.operando_a = 32'd1; bus.operando_b = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign_dones", 64'(dones),         64'd1);
        chk("ign_lat",   64'(first_done),    64'd34);
        chk("ign_res",   64'(bus.resultado), 64'd15);
        chk("ign_busy",  64'(bus.busy),      64'h0);

        // Reset at cycle 10 of a DIV aborts it without a done pulse.
        bus.start = 1'b1; bus.opcode = OP_DIV; bus.operando_a = 32'd100; bus.operando_b = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("abort_res",   64'(bus.resultado), 64'h0);
        chk("abort_flags", 64'(flags()),       64'(5'b00010));
        chk("abort_busy",  64'(bus.busy),      64'h0);
        chk("abort_done",  64'(bus.done),      64'h0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        chk("abort_nodone", 64'(dones), 64'd0);

        op_check("hlt",     OP_HLT, 32'h1234_5678, 32'h9ABC_DEF0, 2, 32'h0000_0000, 5'b00011);
        op_check("xor_b2b", OP_XOR, 32'hF0F0_F0F0, 32'hFFFF_0000, 2, 32'h0F0F_F0F0, 5'b00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
